// File: rtl/sid_pot_ctrl.sv
// SID POTX/POTY measurement sequencer: alternating discharge/charge phases, charge time -> 8-bit pot value.
// Latency: results land on potx/poty with pot_valid on the clk edge of the final charge-phase tick (one per 2*2^CNT_W ticks).
// Backpressure: none; results are strobed once per period and held until the next update.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   phi2       phi2 already synchronised to clk; state advances on its falling edge
//   charged    [0]=POTX pin, [1]=POTY pin reads back as charged (already synchronised)
//   discharge  registered; 1 = sink current on both POT pins
//   potx/poty  measured values (all-ones when the pin never charged in time)
//   pot_valid  one-clk strobe when potx/poty update
module sid_pot_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             phi2,
    input  logic [1:0]       charged,
    output logic             discharge,
    output logic [CNT_W-1:0] potx,
    output logic [CNT_W-1:0] poty,
    output logic             pot_valid
);

    typedef enum logic {
        ST_DISCHARGE = 1'b0,
        ST_CHARGE    = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             phi2_d;
    logic             tick;
    logic             cnt_last;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cap_x;
    logic [CNT_W-1:0] cap_y;
    logic [1:0]       done;
    logic [1:0]       hit;

    // phi2_d resets low, so a low phi2 right after reset cannot fake a falling edge.
    assign tick     = phi2_d & ~phi2;
    assign cnt_last = (cnt == {CNT_W{1'b1}});
    // First rising observation of each pin during a charge phase.
    assign hit      = charged & ~done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phi2_d <= 1'b0;
        end else begin
            phi2_d <= phi2;
        end
    end

    // Phase changes only on the last tick of each phase.
    always_comb begin
        state_nxt = state;
        if (tick && cnt_last) begin
            case (state)
                ST_DISCHARGE: state_nxt = ST_CHARGE;
                ST_CHARGE:    state_nxt = ST_DISCHARGE;
                default:      state_nxt = ST_DISCHARGE;
            endcase
        end
    end

    // discharge is registered from the next state so it moves on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_DISCHARGE;
            discharge <= 1'b1;
        end else begin
            state     <= state_nxt;
            discharge <= (state_nxt == ST_DISCHARGE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            done      <= '0;
            cap_x     <= '0;
            cap_y     <= '0;
            potx      <= '0;
            poty      <= '0;
            pot_valid <= 1'b0;
        end else begin
            pot_valid <= 1'b0;
            if (tick) begin
                cnt <= cnt + CNT_W'(1);
                if (state == ST_DISCHARGE) begin
                    // Pins are held low here; arm both channels for the coming charge phase.
                    if (cnt_last) begin
                        done <= '0;
                    end
                end else begin
                    if (hit[0]) begin
                        cap_x   <= cnt;
                        done[0] <= 1'b1;
                    end
                    if (hit[1]) begin
                        cap_y   <= cnt;
                        done[1] <= 1'b1;
                    end
                    // Uses done from before this tick: a first hit on the last tick
                    // counts as "never charged" and reports all-ones.
                    if (cnt_last) begin
                        potx      <= done[0] ? cap_x : '1;
                        poty      <= done[1] ? cap_y : '1;
                        pot_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/sid_pot_ctrl.md
Name: sid_pot_ctrl

Overview:
Sequences the SID POTX/POTY measurement cycle on the POT pad datapath. Alternates a discharge phase, which drives pot_o.discharge to sink the external capacitor, with a charge phase that times how long each pin takes to read back as charged. Converts the charge time into 8-bit POTX/POTY register values. Sits between the pad I/O block (pot_o.discharge out, pot_i.charged in) and the register file (POTX/POTY read data), and advances once per falling edge of phi2.

Parameters:
CNT_W, 8, counter/result width; each phase lasts 2^CNT_W phi2 cycles (256 by default).

Ports:
clk  input  1  FPGA system clock.
rst  input  1  reset, asynchronous, active-high.
phi2  input  1  phi2 already synchronised to clk (bus_i.phi2).
charged  input  2  pot_i.charged; bit0 POTX, bit1 POTY; already double-registered.
discharge  output  1  to pot_o.discharge; 1 = sink current on both POT pins.
potx  output  CNT_W  POTX register value.
poty  output  CNT_W  POTY register value.
pot_valid  output  1  one-clk strobe when potx/poty update.

Behaviour:
- Tick generation:
  - phi2_d <= phi2 each clk.
  - tick = phi2_d & ~phi2 (falling edge, combinational from registers).
  - All state below advances only on clk edges where tick=1.
  - Reset value of phi2_d is 0, so no spurious tick follows reset.
- State machine, two states, reset state DISCHARGE:
  - DISCHARGE: discharge=1; charged input ignored; cnt increments per tick. On a tick with cnt==2^CNT_W-1: cnt wraps to 0, go to CHARGE, clear done[1:0].
  - CHARGE: discharge=0; cnt increments per tick. Per channel i, on a tick with done[i]==0 and charged[i]==1: cap[i] <= cnt, done[i] <= 1. A later deassertion of charged[i] has no effect (first-hit capture).
  - On a tick with cnt==2^CNT_W-1 in CHARGE: potx/poty <= done[i] ? cap[i] : all-ones. If charged[i] is first seen on this same tick, the result is all-ones. Then cnt wraps to 0, go to DISCHARGE, pot_valid=1 for exactly that clk.
- discharge is a registered output equal to (state==DISCHARGE). It changes on the same clk edge as the state and is never combinational from inputs.
- Cycle period: 2*2^CNT_W ticks (512 at default); pot_valid pulses once per period.
- Result latency: values appear on potx/poty on the clk edge of the final CHARGE tick, concurrent with pot_valid. Values are held stable until the next update.
- Reset (asynchronous assert, any time, including mid-phase):
  - state=DISCHARGE, cnt=0, done=0, cap=0, potx=0, poty=0, pot_valid=0, discharge=1, phi2_d=0.
  - The first valid result appears 512 ticks after reset release.
- Both channels are independent; simultaneous first-hits on the same tick both capture the same cnt.
- phi2 stuck high or low: no ticks, all state frozen, discharge holds its level.
- Counter arithmetic is unsigned CNT_W-bit with natural wrap; no saturation logic other than the all-ones default.

Test Plan:
- Reset then 256 phi2 periods with charged=00: discharge=1 throughout. discharge falls on the tick with cnt=255 → 0; pot_valid stays 0.
- Assert charged[0] at charge-phase cnt=100 and charged[1] at cnt=37 (sampled on a tick): at end of charge, pot_valid pulses once, potx=100 (0x64), poty=37 (0x25). discharge returns to 1 on the same edge.
- charged=00 for the whole charge phase: potx=0xFF, poty=0xFF. charged asserted only at cnt=255: also 0xFF.
- charged[0] high from cnt=10 to cnt=20, then low, then high again at cnt=50: potx=10 (first-hit only). charged pulses during DISCHARGE are ignored.
- Assert rst at charge-phase cnt=128: all outputs return to reset values immediately (potx=poty=0, discharge=1, no pot_valid). The next pot_valid occurs exactly 512 ticks after release.
- Hold phi2 static for 1000 clks mid-charge: cnt, outputs and discharge unchanged. Resuming phi2 continues from the same cnt.
